seq_mult_op_sequencer: RTL and testbench

//  Front-end/back-end controller for the 6-bit sequential right-shift multiplier (unsigned_seq_mult_RS).
//  - Accepts operand pairs on a valid/ready handshake.
//  - Drives the multiplier's load/a/b for one operation at a time and waits out its fixed shift sequence.
//  - Captures the finished product into a small result FIFO, drained on a valid/ready handshake.

---
 rtl/seq_mult_op_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_seq_mult_op_sequencer.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_op_sequencer.sv
// Operand/result sequencer wrapped around a handshake-free sequential multiplier.
// Accepts one operand pair at a time, loads the multiplier, waits out its shift sequence,
// then pushes the product into a small first-word-fall-through result FIFO.
// Optional running accumulation of products is enabled with the macro SEQ_MULT_ACC_EN.
module seq_mult_op_sequencer #(
  parameter int unsigned W           = 6,
  parameter int unsigned MULT_CYCLES = 6,
  parameter int unsigned FIFO_DEPTH  = 2,
  parameter int unsigned ACC_EXT     = 4,
`ifdef SEQ_MULT_ACC_EN
  localparam int unsigned RES_W      = 2 * W + ACC_EXT
`else
  localparam int unsigned RES_W      = 2 * W
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid_i,
  output logic             op_ready_o,
  input  logic [W-1:0]     op_a_i,
  input  logic [W-1:0]     op_b_i,
  output logic             mul_load_o,
  output logic [W-1:0]     mul_a_o,
  output logic [W-1:0]     mul_b_o,
  input  logic [2*W:0]     mul_product_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [RES_W-1:0] res_data_o,
`ifdef SEQ_MULT_ACC_EN
  input  logic             acc_clr_i,
`endif
  output logic             busy_o
);

  localparam int unsigned CntW   = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;
  localparam int unsigned PtrW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CountW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StLoad, StWait, StCapt} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]      mul_a_q, mul_a_d;
  logic [W-1:0]      mul_b_q, mul_b_d;
  logic              push, pop;
  logic [RES_W-1:0]  push_data;
  logic [2*W-1:0]    product;
  logic              unused_product_msb;

  logic [RES_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CountW-1:0] count_q, count_d;
  logic [RES_W-1:0]  last_q;
  logic              fifo_empty, fifo_full;

  // Top product bit can never be set for unsigned W x W operands.
  assign product            = mul_product_i[2*W-1:0];
  assign unused_product_msb = mul_product_i[2*W];

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CountW'(FIFO_DEPTH));

  // Next-state logic; op_ready is only ever high in idle so one operation is in flight at most.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    op_ready_o = 1'b0;
    push       = 1'b0;
    unique case (state_q)
      StIdle: begin
        op_ready_o = !fifo_full;
        if (op_valid_i && !fifo_full) begin
          mul_a_d = op_a_i;
          mul_b_d = op_b_i;
          state_d = StLoad;
        end
      end
      StLoad: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(MULT_CYCLES - 1)) begin
          state_d = StCapt;
        end
      end
      StCapt: begin
        push    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, wait counter and registered operands driven to the multiplier.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
    end
  end

  assign mul_load_o = (state_q == StLoad);
  assign busy_o     = (state_q != StIdle);
  assign mul_a_o    = mul_a_q;
  assign mul_b_o    = mul_b_q;

`ifdef SEQ_MULT_ACC_EN
  logic [RES_W-1:0] acc_q, acc_d, acc_sum;

  // Running sum; acc_clr in the capture cycle restarts the sum from this product alone.
  always_comb begin
    acc_sum   = (acc_clr_i ? '0 : acc_q) + RES_W'(product);
    push_data = acc_sum;
    acc_d     = acc_q;
    if (push) begin
      acc_d = acc_sum;
    end else if (acc_clr_i) begin
      acc_d = '0;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end
`else
  logic [31:0] unused_acc_ext;

  assign unused_acc_ext = 32'(ACC_EXT);
  assign push_data      = product;
`endif

  // A pop while empty is ignored; push and pop together leave the count unchanged.
  assign pop     = res_ready_i && !fifo_empty;
  assign count_d = count_q + CountW'(push) - CountW'(pop);

  // FIFO pointers, occupancy and the held copy of the last head shown while empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (!fifo_empty) begin
        last_q <= mem_q[rd_ptr_q];
      end
      count_q <= count_d;
    end
  end

  // FIFO storage; entries are only read while valid, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign res_valid_o = !fifo_empty;
  assign res_data_o  = fifo_empty ? last_q : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_seq_mult_op_sequencer.sv
// Bench for seq_mult_op_sequencer: stands in for the shift multiplier, keeps a timeline/queue
// model of the sequencer, compares every cycle and pins the model with literal expectations.
module tb_seq_mult_op_sequencer;

  localparam int W  = 6;
  localparam int MC = 6;
  localparam int FD = 2;
`ifdef SEQ_MULT_ACC_EN
  localparam int RES_W = 16;
`else
  localparam int RES_W = 12;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             op_valid, op_ready;
  logic [W-1:0]     op_a, op_b;
  logic             mul_load;
  logic [W-1:0]     mul_a, mul_b;
  logic [2*W:0]     mul_product;
  logic             res_valid, res_ready;
  logic [RES_W-1:0] res_data;
  logic             busy;
`ifdef SEQ_MULT_ACC_EN
  logic             acc_clr;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int load_cnt = 0;
  int accept_log[$];
  int pop_cyc[$];
  logic [RES_W-1:0] pop_log[$];

  always #5 clk = ~clk;

  seq_mult_op_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .op_valid_i   (op_valid),
    .op_ready_o   (op_ready),
    .op_a_i       (op_a),
    .op_b_i       (op_b),
    .mul_load_o   (mul_load),
    .mul_a_o      (mul_a),
    .mul_b_o      (mul_b),
    .mul_product_i(mul_product),
    .res_valid_o  (res_valid),
    .res_ready_i  (res_ready),
    .res_data_o   (res_data),
`ifdef SEQ_MULT_ACC_EN
    .acc_clr_i    (acc_clr),
`endif
    .busy_o       (busy)
  );

  function automatic logic [11:0] mul12(input logic [5:0] a, input logic [5:0] b);
    logic [11:0] x;
    x = {6'd0, a};
    return x * {6'd0, b};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Multiplier stand-in: product is garbage until MC shift edges after the load edge.
  int mk;
  logic [W-1:0] ma, mb;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_product <= '0;
      mk          <= MC;
      ma          <= '0;
      mb          <= '0;
    end else if (mul_load) begin
      ma          <= mul_a;
      mb          <= mul_b;
      mk          <= 0;
      mul_product <= {1'b0, ~mul12(mul_a, mul_b)};
    end else if (mk < MC) begin
      mk <= mk + 1;
      if (mk == MC - 1) mul_product <= {1'b0, mul12(ma, mb)};
    end
  end

  // Event logs taken from pre-edge values.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && mul_load) load_cnt <= load_cnt + 1;
    if (!rst && op_valid && op_ready) accept_log.push_back(cyc);
    if (!rst && res_valid && res_ready) begin
      pop_log.push_back(res_data);
      pop_cyc.push_back(cyc);
    end
  end

  // Reference model: age counts edges since accept (0 = load cycle, MC+1 = capture cycle).
  logic [RES_W-1:0] mq[$];
  bit               m_busy;
  int               m_age;
  logic [W-1:0]     m_a, m_b;
  logic [RES_W-1:0] m_last, m_acc;
  logic             e_ready, e_busy, e_load, e_rv;
  logic [W-1:0]     e_ma, e_mb;
  logic [RES_W-1:0] e_rd;

  task automatic mderive();
    e_busy  = m_busy;
    e_load  = m_busy && (m_age == 0);
    e_ready = !m_busy && (mq.size() < FD);
    e_rv    = (mq.size() != 0);
    e_rd    = e_rv ? mq[0] : m_last;
  endtask

  task automatic mreset();
    mq.delete();
    m_busy = 0;
    m_age  = 0;
    m_a    = '0;
    m_b    = '0;
    m_last = '0;
    m_acc  = '0;
    e_ma   = '0;
    e_mb   = '0;
    mderive();
  endtask

  initial begin
    bit accept, capt;
    logic [RES_W-1:0] v;
    mreset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mreset();
      end else begin
        accept = op_valid && !m_busy && (mq.size() < FD);
        capt   = m_busy && (m_age == MC + 1);
        if (res_ready && mq.size() != 0) m_last = mq.pop_front();
        if (capt) begin
          v = RES_W'(mul12(m_a, m_b));
`ifdef SEQ_MULT_ACC_EN
          v     = (acc_clr ? '0 : m_acc) + v;
          m_acc = v;
`endif
          mq.push_back(v);
          m_busy = 0;
        end else begin
          if (m_busy) m_age++;
`ifdef SEQ_MULT_ACC_EN
          if (acc_clr) m_acc = '0;
`endif
        end
        if (accept) begin
          m_busy = 1;
          m_age  = 0;
          m_a    = op_a;
          m_b    = op_b;
          e_ma   = op_a;
          e_mb   = op_b;
        end
        mderive();
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("op_ready", op_ready, e_ready);
      check("busy", busy, e_busy);
      check("mul_load", mul_load, e_load);
      check("mul_a", mul_a, e_ma);
      check("mul_b", mul_b, e_mb);
      check("res_valid", res_valid, e_rv);
      check("res_data", res_data, e_rd);
    end
  end

  task automatic send(input logic [5:0] a, input logic [5:0] b);
    int k = 0;
    @(negedge clk);
    op_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    while (!op_ready && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("send_accept_in_time", op_ready, 1);
    @(posedge clk);
    #1 op_valid = 1'b0;
  endtask

  task automatic wait_pops(input int n, input int budget);
    int k = 0;
    while (pop_log.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("pops_in_time", pop_log.size() >= n, 1);
  endtask

  task automatic wait_rv();
    int k = 0;
    @(negedge clk);
    while (!res_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("res_valid_in_time", res_valid, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base, acc_c, loads0;
    op_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    res_ready = 1'b0;
`ifdef SEQ_MULT_ACC_EN
    acc_clr   = 1'b1;  // keeps pushed values equal to the raw product until the acc test
`endif
    repeat (2) @(negedge clk);
    check("rst_op_ready", op_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_mul_load", mul_load, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_mul_a", mul_a, 0);
    #2 rst = 1'b0;

    // Single op: result pops one edge after it becomes visible (8 edges after accept).
    res_ready = 1'b1;
    base   = pop_log.size();
    loads0 = load_cnt;
    send(6'd13, 6'd11);
    acc_c = accept_log[$];
    wait_pops(base + 1, 50);
    check("t1_data", pop_log[base], 143);
    check("t1_accept_to_pop_edges", pop_cyc[base] - acc_c, 9);
    check("t1_load_pulses", load_cnt - loads0, 1);
    @(negedge clk);
    check("t1_busy_after", busy, 0);

    // Corners, in order.
    base = pop_log.size();
    send(6'd0, 6'd63);
    send(6'd63, 6'd63);
    send(6'd1, 6'd1);
    wait_pops(base + 3, 100);
    check("t2_0x63", pop_log[base], 0);
    check("t2_63x63", pop_log[base + 1], 3969);
    check("t2_1x1", pop_log[base + 2], 1);

    // Backpressure: FIFO full blocks the third op until the first pop.
    @(negedge clk);
    res_ready = 1'b0;
    base = pop_log.size();
    send(6'd2, 6'd3);
    send(6'd4, 6'd5);
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("t3_full_op_ready", op_ready, 0);
    check("t3_full_res_valid", res_valid, 1);
    fork
      send(6'd7, 6'd7);
      begin
        repeat (3) @(negedge clk);
        res_ready = 1'b1;
      end
    join
    wait_pops(base + 3, 100);
    check("t3_first", pop_log[base], 6);
    check("t3_second", pop_log[base + 1], 20);
    check("t3_third", pop_log[base + 2], 49);
    check("t3_accept_after_pop", accept_log[$] > pop_cyc[base], 1);

    // Pop of the held entry in exactly the capture cycle of the next op.
    @(negedge clk);
    res_ready = 1'b0;
    base = pop_log.size();
    send(6'd5, 6'd6);
    wait_rv();
    send(6'd7, 6'd8);
    repeat (7) @(posedge clk);
    #1 res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    @(negedge clk);
    check("t4_one_popped", pop_log.size(), base + 1);
    check("t4_popped_old", pop_log[base], 30);
    check("t4_still_valid", res_valid, 1);
    check("t4_head_new", res_data, 56);
    res_ready = 1'b1;
    wait_pops(base + 2, 10);
    @(negedge clk);
    check("t4_second_pop", pop_log[base + 1], 56);
    check("t4_empty", res_valid, 0);
    check("t4_empty_holds_head", res_data, 56);

    // Reset in WAIT with cnt=3 while the FIFO holds an entry.
    res_ready = 1'b0;
    send(6'd2, 6'd2);
    wait_rv();
    send(6'd5, 6'd5);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("t5_op_ready", op_ready, 1);
    check("t5_busy", busy, 0);
    check("t5_mul_load", mul_load, 0);
    check("t5_mul_a", mul_a, 0);
    check("t5_mul_b", mul_b, 0);
    check("t5_res_valid", res_valid, 0);
    check("t5_res_data", res_data, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    base = pop_log.size();
    res_ready = 1'b1;
    send(6'd9, 6'd9);
    wait_pops(base + 1, 50);
    check("t5_9x9", pop_log[base], 81);
    repeat (12) @(negedge clk);
    check("t5_no_stale_push", pop_log.size(), base + 1);

`ifdef SEQ_MULT_ACC_EN
    // Accumulation, clear in the capture cycle, and wrap at 16 bits.
    @(negedge clk);
    acc_clr = 1'b0;
    base = pop_log.size();
    send(6'd10, 6'd10);
    send(6'd20, 6'd20);
    wait_pops(base + 2, 100);
    check("t6_acc_100", pop_log[base], 100);
    check("t6_acc_500", pop_log[base + 1], 500);
    send(6'd3, 6'd3);
    repeat (7) @(posedge clk);
    #1 acc_clr = 1'b1;
    @(posedge clk);
    #1 acc_clr = 1'b0;
    wait_pops(base + 3, 20);
    check("t6_clr_in_capt", pop_log[base + 2], 9);
    for (int i = 0; i < 300; i++) send(6'd63, 6'd63);
    wait_pops(base + 303, 100);
    check("t6_wrap_after_17", pop_log[base + 19], 1946);
    check("t6_wrap_after_300", pop_log[base + 302], 11061);
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
